// File: rtl/beams_sort_pkg.sv
// Shared types and constants for the beam top-16 sorter.
// Slot power is held at a fixed maximum width so that one slot type serves any PWR_WIDTH up to 64.
package beams_sort_pkg;

   localparam int TOPK          = 16;
   localparam int IDX_WIDTH     = 8;
   localparam logic [IDX_WIDTH-1:0] IDX_NONE = 8'hFF;
   localparam int PWR_MAX_WIDTH = 64;

   typedef logic [PWR_MAX_WIDTH-1:0] slot_pwr_t;

   typedef struct packed {
      logic                 valid;
      logic [IDX_WIDTH-1:0] idx;
      slot_pwr_t            pwr;
   } beam_slot_t;

   // A beat travelling down the insertion pipeline; ins=0 with eop=1 marks a dropped closing beat.
   typedef struct packed {
      logic                 ins;
      logic                 sop;
      logic                 eop;
      logic [IDX_WIDTH-1:0] idx;
      slot_pwr_t            pwr;
   } beat_t;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      FLUSH,
      OUT
   } sort_state_e;

endpackage

// File: rtl/beams_sort_cell.sv
// One slot of the insertion-sorted list: keeps its beam, or takes the new beam or the slot above.
// Also produces its compare bit for the following beat against the slot's post-update contents.
module beams_sort_cell
   import beams_sort_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       upd,
   input  logic       clear,
   input  logic       gt_own,
   input  logic       gt_up,
   input  beam_slot_t upper,
   input  beam_slot_t new_beam,
   input  slot_pwr_t  cmp_pwr,
   output beam_slot_t slot,
   output beam_slot_t slot_next,
   output logic       gt
);

   // gt is monotonic down the list, so gt_up implies gt_own; a clearing beat shifts in empties.
   always_comb begin
      slot_next = slot;
      if (upd) begin
         if (gt_own && !gt_up) begin
            slot_next = new_beam;
         end else if (gt_up) begin
            slot_next = clear ? '0 : upper;
         end
      end
   end

   assign gt = !slot_next.valid || (cmp_pwr > slot_next.pwr);

   always_ff @(posedge clk) begin
      if (reset) begin
         slot <= '0;
      end else begin
         slot <= slot_next;
      end
   end

endmodule

// File: rtl/beams_topk_sort.sv
// Streaming top-16 beam sorter: input register, compare vector, slot update, then snapshot and output.
// Optional macro BEAMS_SORT_PWR_OUT_EN adds the o_sort_pwr port and its output registers.
module beams_topk_sort
   import beams_sort_pkg::*;
#(
   parameter int PWR_WIDTH = 32,
   parameter int NUM_BEAMS = 64
) (
   input  logic                                i_clk,
   input  logic                                i_reset,
   input  logic                                i_pwr_vld,
   input  logic                                i_pwr_sop,
   input  logic                                i_pwr_eop,
   input  logic [PWR_WIDTH-1:0]                i_pwr_data,
   output logic [TOPK-1:0][IDX_WIDTH-1:0]      o_sort_idx,
`ifdef BEAMS_SORT_PWR_OUT_EN
   output logic [TOPK-1:0][PWR_WIDTH-1:0]      o_sort_pwr,
`endif
   output logic                                o_sort_sop,
   output logic                                o_err
);

   localparam logic [8:0] CNT_FULL = 9'(NUM_BEAMS);

   sort_state_e col_state, col_state_nx;
   sort_state_e drn_state, drn_state_nx;
   logic        flush_half, flush_half_nx;
   logic [8:0]  cnt, cnt_nx;
   logic        err_nx;
   beat_t       s1_nx, s1, s2;
   logic [TOPK-1:0] gt_vec, gt_q, gt_up;
   beam_slot_t  slot_q  [TOPK];
   beam_slot_t  slot_nx [TOPK];
   beam_slot_t  upper   [TOPK];
   beam_slot_t  new_beam;
   logic [TOPK-1:0][IDX_WIDTH-1:0] snap_idx;

   // Collect side works on the raw input so a new symbol can start while the previous one drains.
   always_comb begin
      col_state_nx = col_state;
      cnt_nx       = cnt;
      err_nx       = 1'b0;
      s1_nx        = '0;
      if (i_pwr_vld) begin
         if (i_pwr_sop) begin
            s1_nx.ins    = 1'b1;
            s1_nx.sop    = 1'b1;
            s1_nx.eop    = i_pwr_eop;
            s1_nx.pwr    = slot_pwr_t'(i_pwr_data);
            cnt_nx       = 9'd1;
            col_state_nx = i_pwr_eop ? IDLE : COLLECT;
         end else if (col_state == COLLECT) begin
            // An overflow beat is dropped, but its eop still closes the symbol.
            if (cnt == CNT_FULL) begin
               err_nx = 1'b1;
            end else begin
               s1_nx.ins = 1'b1;
               s1_nx.idx = cnt[IDX_WIDTH-1:0];
               s1_nx.pwr = slot_pwr_t'(i_pwr_data);
               cnt_nx    = cnt + 9'd1;
            end
            s1_nx.eop = i_pwr_eop;
            if (i_pwr_eop) begin
               col_state_nx = IDLE;
            end
         end
      end
   end

   // Drain side follows the closing beat; symbols must end at least 3 cycles apart.
   always_comb begin
      drn_state_nx  = drn_state;
      flush_half_nx = 1'b0;
      unique case (drn_state)
         FLUSH: begin
            flush_half_nx = !flush_half;
            if (flush_half) begin
               drn_state_nx = OUT;
            end
         end
         OUT:     drn_state_nx = s1.eop ? FLUSH : IDLE;
         default: if (s1.eop) drn_state_nx = FLUSH;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         col_state  <= IDLE;
         drn_state  <= IDLE;
         flush_half <= 1'b0;
         cnt        <= '0;
         s1         <= '0;
         s2         <= '0;
         gt_q       <= '0;
      end else begin
         col_state  <= col_state_nx;
         drn_state  <= drn_state_nx;
         flush_half <= flush_half_nx;
         cnt        <= cnt_nx;
         s1         <= s1_nx;
         s2         <= s1;
         gt_q       <= s1.sop ? '1 : gt_vec;
      end
   end

   always_comb begin
      upper[0] = '0;
      for (int i = 1; i < TOPK; i++) begin
         upper[i] = slot_q[i-1];
      end
   end

   assign gt_up    = {gt_q[TOPK-2:0], 1'b0};
   assign new_beam = '{valid: 1'b1, idx: s2.idx, pwr: s2.pwr};

   for (genvar g = 0; g < TOPK; g++) begin : g_cell
      beams_sort_cell u_cell (
         .clk       (i_clk),
         .reset     (i_reset),
         .upd       (s2.ins),
         .clear     (s2.sop),
         .gt_own    (gt_q[g]),
         .gt_up     (gt_up[g]),
         .upper     (upper[g]),
         .new_beam  (new_beam),
         .cmp_pwr   (s1.pwr),
         .slot      (slot_q[g]),
         .slot_next (slot_nx[g]),
         .gt        (gt_vec[g])
      );
   end

   // The snapshot is the second slot bank: it freezes the finished list while a new symbol fills.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         snap_idx   <= {TOPK{IDX_NONE}};
         o_sort_idx <= {TOPK{IDX_NONE}};
         o_sort_sop <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_sort_sop <= (drn_state == OUT);
         o_err      <= err_nx;
         if (s2.eop) begin
            for (int i = 0; i < TOPK; i++) begin
               snap_idx[i] <= slot_nx[i].valid ? slot_nx[i].idx : IDX_NONE;
            end
         end
         if (drn_state == OUT) begin
            o_sort_idx <= snap_idx;
         end
      end
   end

`ifdef BEAMS_SORT_PWR_OUT_EN
   logic [TOPK-1:0][PWR_WIDTH-1:0] snap_pwr;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         snap_pwr   <= '0;
         o_sort_pwr <= '0;
      end else begin
         if (s2.eop) begin
            for (int i = 0; i < TOPK; i++) begin
               snap_pwr[i] <= slot_nx[i].valid ? slot_nx[i].pwr[PWR_WIDTH-1:0] : '0;
            end
         end
         if (drn_state == OUT) begin
            o_sort_pwr <= snap_pwr;
         end
      end
   end
`endif

endmodule

// File: tb/tb_beams_topk_sort.sv
// Randomized bench for beams_topk_sort against a stable top-16 selection model.
// Powers are also compared when BEAMS_SORT_PWR_OUT_EN is defined.
module tb_beams_topk_sort;

   localparam int NB = 64;

   typedef struct {
      int                eop_cyc;
      logic [15:0][7:0]  idx;
      logic [15:0][31:0] pwr;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vld = 1'b0;
   logic sop = 1'b0;
   logic eop = 1'b0;
   logic [31:0] data = '0;
   logic [15:0][7:0]  sort_idx;
   logic [15:0][31:0] sort_pwr;
   logic sort_sop;
   logic err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int err_cnt = 0;
   int last_pulse = 0;
   logic [31:0] pwrs [80];
   rec_t exp_q [$];
   rec_t res_q [$];
   rec_t mon_r;

   beams_topk_sort #(.PWR_WIDTH(32), .NUM_BEAMS(NB)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_pwr_vld  (vld),
      .i_pwr_sop  (sop),
      .i_pwr_eop  (eop),
      .i_pwr_data (data),
      .o_sort_idx (sort_idx),
`ifdef BEAMS_SORT_PWR_OUT_EN
      .o_sort_pwr (sort_pwr),
`endif
      .o_sort_sop (sort_sop),
      .o_err      (err)
   );

`ifndef BEAMS_SORT_PWR_OUT_EN
   assign sort_pwr = '0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sort_sop) begin
         mon_r.eop_cyc = cyc;
         mon_r.idx     = sort_idx;
         mon_r.pwr     = sort_pwr;
         res_q.push_back(mon_r);
      end
      if (err) err_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic s, input logic e, input logic [31:0] p);
      vld  = v;
      sop  = s;
      eop  = e;
      data = p;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      vld = 1'b0;
      sop = 1'b0;
      eop = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Stable top-16: highest power first, lowest beam index wins ties; beams beyond NB are dropped.
   task automatic sendSymbol(input int n);
      rec_t e;
      bit   taken [80];
      int   m, best;
      m = (n > NB) ? NB : n;
      foreach (taken[j]) taken[j] = 1'b0;
      for (int r = 0; r < 16; r++) begin
         best = -1;
         for (int j = 0; j < m; j++) begin
            if (!taken[j] && (best < 0 || pwrs[j] > pwrs[best])) best = j;
         end
         if (best < 0) begin
            e.idx[r] = 8'hFF;
            e.pwr[r] = '0;
         end else begin
            e.idx[r] = 8'(best);
            e.pwr[r] = pwrs[best];
            taken[best] = 1'b1;
         end
      end
      for (int j = 0; j < n; j++) begin
         applyStimulus(1'b1, j == 0, j == n - 1, pwrs[j]);
      end
      e.eop_cyc = cyc;
      exp_q.push_back(e);
      vld = 1'b0;
      sop = 1'b0;
      eop = 1'b0;
   endtask

   task automatic checkOne();
      rec_t e, r;
      e = exp_q.pop_front();
      for (int w = 0; w < 300 && res_q.size() == 0; w++) @(posedge clk);
      if (res_q.size() == 0) begin
         checkOutput("result_timeout", 64'd0, 64'd1);
         return;
      end
      r = res_q.pop_front();
      last_pulse = r.eop_cyc;
      checkOutput("latency", 64'(r.eop_cyc - e.eop_cyc), 64'd4);
      for (int s = 0; s < 16; s++) begin
         checkOutput($sformatf("idx%0d", s), 64'(r.idx[s]), 64'(e.idx[s]));
`ifdef BEAMS_SORT_PWR_OUT_EN
         checkOutput($sformatf("pwr%0d", s), 64'(r.pwr[s]), 64'(e.pwr[s]));
`endif
      end
   endtask

   task automatic checkResults();
      while (exp_q.size() > 0) checkOne();
   endtask

   initial begin
      int p0, e0, n, gap;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_idx", 64'(sort_idx[0]), 64'hFF);
      checkOutput("rst_idx15", 64'(sort_idx[15]), 64'hFF);
      checkOutput("rst_sop", 64'(sort_sop), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      #1;

      // Stray beats without sop while idle must be ignored.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);

      for (int j = 0; j < NB; j++) pwrs[j] = 32'(j);
      sendSymbol(NB);
      idleCycles(8);
      checkResults();

      for (int j = 0; j < NB; j++) pwrs[j] = 32'd100;
      sendSymbol(NB);
      idleCycles(8);
      checkResults();

      pwrs[0] = 7; pwrs[1] = 3; pwrs[2] = 9; pwrs[3] = 1; pwrs[4] = 5;
      sendSymbol(5);
      idleCycles(8);
      checkResults();

      for (int j = 0; j < NB; j++) pwrs[j] = 32'(j);
      sendSymbol(NB);
      for (int j = 0; j < NB; j++) pwrs[j] = 32'(NB - 1 - j);
      sendSymbol(NB);
      idleCycles(8);
      checkOne();
      p0 = last_pulse;
      checkOne();
      checkOutput("b2b_gap", 64'(last_pulse - p0), 64'd64);

      e0 = err_cnt;
      for (int j = 0; j < 65; j++) pwrs[j] = $urandom;
      pwrs[64] = 32'hFFFF_FFFF;
      sendSymbol(65);
      idleCycles(8);
      checkResults();
      checkOutput("overflow_err", 64'(err_cnt - e0), 64'd1);

      for (int j = 0; j < 30; j++) applyStimulus(1'b1, j == 0, 1'b0, $urandom);
      vld = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_idx0", 64'(sort_idx[0]), 64'hFF);
      checkOutput("mid_rst_idx7", 64'(sort_idx[7]), 64'hFF);
      checkOutput("mid_rst_sop", 64'(sort_sop), 64'd0);
      #1;
      idleCycles(12);
      checkOutput("mid_rst_no_pulse", 64'(res_q.size()), 64'd0);

      e0 = err_cnt;
      for (int k = 0; k < 10; k++) begin
         n = $urandom_range(1, NB);
         for (int j = 0; j < n; j++) pwrs[j] = (k % 2 == 1) ? 32'($urandom_range(0, 15)) : $urandom;
         sendSymbol(n);
         gap = (n < 3) ? 3 : $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom);
         vld = 1'b0;
      end
      idleCycles(8);
      checkResults();
      checkOutput("no_spurious_err", 64'(err_cnt - e0), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
